// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants (NOP encoding, PC step, default widths and reset PC).
// Imported by fetch_unit and its FIFO; the same values are reused by decode/datapath.
package fetch_unit_pkg;
   localparam int          DEF_PC_W     = 8;
   localparam int          DEF_INS_W    = 32;
   localparam int          PC_STEP      = 4;
   localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
   localparam logic [7:0]  DEF_RESET_PC = 8'h00;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and the
// valid/ready instruction output. master = fetch unit, slave = memory/consumer side.
interface fetch_if #(
   parameter int PC_W  = 8,
   parameter int INS_W = 32
);
   logic             imem_req;
   logic [PC_W-1:0]  imem_addr;
   logic             imem_valid;
   logic [INS_W-1:0] imem_rdata;
   logic             redirect_en;
   logic [PC_W-1:0]  redirect_pc;
   logic             inst_valid;
   logic             inst_ready;
   logic [INS_W-1:0] instruction;
   logic [PC_W-1:0]  inst_pc;

   modport master (
      output imem_req, imem_addr, inst_valid, instruction, inst_pc,
      input  imem_valid, imem_rdata, redirect_en, redirect_pc, inst_ready
   );
   modport slave (
      input  imem_req, imem_addr, inst_valid, instruction, inst_pc,
      output imem_valid, imem_rdata, redirect_en, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH x W synchronous prefetch FIFO with push/pop/flush and occupancy count.
// Flush wins over push and pop; pointers wrap naturally since DEPTH is a power of 2.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 40
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [W-1:0]             i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [W-1:0]             o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign w_push  = i_push && !i_flush;
   assign w_pop   = i_pop && !i_flush && (r_cnt != '0);
   assign o_data  = r_mem[r_rd];
   assign o_count = r_cnt;
   assign o_empty = (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem issue, prefetch queue, redirect flush.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue is presented the same cycle.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              PC_W     = DEF_PC_W,
   parameter int              INS_W    = DEF_INS_W,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
   input  logic     clk,
   input  logic     reset,
   fetch_if.master  fi
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = INS_W + PC_W;

   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  r_req_pc;
   logic             r_inflight;
   logic             r_discard;

   logic             w_issue;
   logic             w_resp;
   logic             w_byp;
   logic             w_vld;
   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic [CW-1:0]    w_count;
   logic [EW-1:0]    w_head;
   logic [INS_W-1:0] w_ins;
   logic [PC_W-1:0]  w_ipc;

   // Queue slots already owned plus the outstanding fetch must leave room for one more.
   assign w_issue = !reset && !fi.redirect_en &&
                    ((w_count + CW'(r_inflight)) < CW'(DEPTH));
   assign w_resp  = fi.imem_valid && r_inflight && !r_discard && !fi.redirect_en;

`ifdef FETCH_BYPASS_EN
   assign w_byp = w_empty && w_resp;
`else
   assign w_byp = 1'b0;
`endif

   assign w_vld  = !reset && !fi.redirect_en && (!w_empty || w_byp);
   assign w_push = w_resp && !(w_byp && fi.inst_ready);
   assign w_pop  = w_vld && fi.inst_ready && !w_empty;

   fetch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  ({fi.imem_rdata, r_req_pc}),
      .i_pop   (w_pop),
      .i_flush (fi.redirect_en),
      .o_data  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   always_comb begin
      w_ins = reset ? '0 : INS_W'(INSTR_NOP);
      w_ipc = '0;
      if (w_byp) begin
         w_ins = fi.imem_rdata;
         w_ipc = r_req_pc;
      end else if (w_vld) begin
         w_ins = w_head[EW-1:PC_W];
         w_ipc = w_head[PC_W-1:0];
      end
   end

   assign fi.imem_req    = w_issue;
   assign fi.imem_addr   = r_pc;
   assign fi.inst_valid  = w_vld;
   assign fi.instruction = w_ins;
   assign fi.inst_pc     = w_ipc;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= {RESET_PC[PC_W-1:2], 2'b00};
         r_req_pc   <= '0;
         r_inflight <= 1'b0;
         r_discard  <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_discard  <= fi.redirect_en;
         if (fi.redirect_en) begin
            r_pc <= {fi.redirect_pc[PC_W-1:2], 2'b00};
         end else if (w_issue) begin
            r_pc     <= r_pc + PC_W'(PC_STEP);
            r_req_pc <= r_pc;
         end
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus a RESET_PC=0xF8 wrap instance.
// Expected columns follow the FETCH_BYPASS_EN setting of the build.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int PC_W  = 8;
   localparam int INS_W = 32;
`ifdef FETCH_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_if #(.PC_W(PC_W), .INS_W(INS_W)) fi ();
   fetch_if #(.PC_W(PC_W), .INS_W(INS_W)) fw ();

   fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(4), .RESET_PC(8'h00)) dut (
      .clk(clk), .reset(reset), .fi(fi.master));
   fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(4), .RESET_PC(8'hF8)) dut_w (
      .clk(clk), .reset(reset), .fi(fw.master));

   // memory model: one-cycle read latency, word = address + 0x100
   logic [PC_W-1:0] m_addr, w_addr;
   always @(posedge clk) begin
      fi.imem_valid <= fi.imem_req;
      m_addr        <= fi.imem_addr;
      fw.imem_valid <= fw.imem_req;
      w_addr        <= fw.imem_addr;
   end
   assign fi.imem_rdata = 32'(m_addr) + 32'h100;
   assign fw.imem_rdata = 32'(w_addr) + 32'h100;

   typedef struct {
      logic       rst;
      logic       redir;
      logic [7:0] rpc;
      logic       rdy;
      logic       ereq;
      logic [7:0] eaddr;
      logic       cv;
      logic       evld;
      logic [7:0] epc;
   } vec_t;

   localparam int N = 40;
   vec_t tbl [N];
   int checks = 0;
   int failures = 0;

   function automatic vec_t mk(logic rst, logic redir, logic [7:0] rpc, logic rdy,
                               logic ereq, logic [7:0] eaddr, logic cv, logic evld,
                               logic [7:0] epc);
      vec_t v;
      v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
      v.ereq = ereq; v.eaddr = eaddr; v.cv = cv; v.evld = evld; v.epc = epc;
      return v;
   endfunction

   task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%h exp=%h", name, row, act, exp);
      end
   endtask

   task automatic fill();
      for (int i = 0; i < 3; i++) tbl[i] = mk(1, 0, 0, 1, 0, 0, 1, 0, 0);
      tbl[3] = mk(0, 0, 0, 1, 1, 8'h00, 1, 0, 0);
`ifdef FETCH_BYPASS_EN
      tbl[4]  = mk(0, 0, 0, 1, 1, 8'h04, 1, 1, 8'h00);
      tbl[5]  = mk(0, 0, 0, 1, 1, 8'h08, 1, 1, 8'h04);
      tbl[6]  = mk(0, 0, 0, 1, 1, 8'h0C, 1, 1, 8'h08);
      tbl[7]  = mk(0, 0, 0, 1, 1, 8'h10, 1, 1, 8'h0C);
      tbl[8]  = mk(0, 0, 0, 0, 1, 8'h14, 1, 1, 8'h10);
      tbl[9]  = mk(0, 0, 0, 0, 1, 8'h18, 1, 1, 8'h10);
      tbl[10] = mk(0, 0, 0, 0, 1, 8'h1C, 1, 1, 8'h10);
      tbl[11] = mk(0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h10);
      tbl[12] = mk(0, 0, 0, 1, 0, 8'h00, 1, 1, 8'h10);
      tbl[13] = mk(0, 0, 0, 1, 1, 8'h20, 1, 1, 8'h14);
      tbl[14] = mk(0, 0, 0, 1, 1, 8'h24, 1, 1, 8'h18);
      tbl[15] = mk(0, 0, 0, 1, 1, 8'h28, 1, 1, 8'h1C);
      tbl[16] = mk(0, 0, 0, 1, 1, 8'h2C, 1, 1, 8'h20);
`else
      tbl[4]  = mk(0, 0, 0, 1, 1, 8'h04, 1, 0, 8'h00);
      tbl[5]  = mk(0, 0, 0, 1, 1, 8'h08, 1, 1, 8'h00);
      tbl[6]  = mk(0, 0, 0, 1, 1, 8'h0C, 1, 1, 8'h04);
      tbl[7]  = mk(0, 0, 0, 1, 1, 8'h10, 1, 1, 8'h08);
      tbl[8]  = mk(0, 0, 0, 0, 1, 8'h14, 1, 1, 8'h0C);
      tbl[9]  = mk(0, 0, 0, 0, 1, 8'h18, 1, 1, 8'h0C);
      tbl[10] = mk(0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h0C);
      tbl[11] = mk(0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h0C);
      tbl[12] = mk(0, 0, 0, 1, 0, 8'h00, 1, 1, 8'h0C);
      tbl[13] = mk(0, 0, 0, 1, 1, 8'h1C, 1, 1, 8'h10);
      tbl[14] = mk(0, 0, 0, 1, 1, 8'h20, 1, 1, 8'h14);
      tbl[15] = mk(0, 0, 0, 1, 1, 8'h24, 1, 1, 8'h18);
      tbl[16] = mk(0, 0, 0, 1, 1, 8'h28, 1, 1, 8'h1C);
`endif
      // redirect cycle: no request; valid in this cycle is not checked
      tbl[17] = mk(0, 1, 8'h42, 1, 0, 8'h00, 0, 0, 0);
      tbl[18] = mk(0, 0, 0, 1, 1, 8'h40, 1, 0, 0);
`ifdef FETCH_BYPASS_EN
      tbl[19] = mk(0, 0, 0, 1, 1, 8'h44, 1, 1, 8'h40);
      tbl[20] = mk(0, 0, 0, 1, 1, 8'h48, 1, 1, 8'h44);
      tbl[21] = mk(0, 0, 0, 1, 1, 8'h4C, 1, 1, 8'h48);
`else
      tbl[19] = mk(0, 0, 0, 1, 1, 8'h44, 1, 0, 0);
      tbl[20] = mk(0, 0, 0, 1, 1, 8'h48, 1, 1, 8'h40);
      tbl[21] = mk(0, 0, 0, 1, 1, 8'h4C, 1, 1, 8'h44);
`endif
      tbl[22] = mk(0, 1, 8'h80, 1, 0, 8'h00, 0, 0, 0);
      tbl[23] = mk(0, 1, 8'h91, 1, 0, 8'h00, 0, 0, 0);
      tbl[24] = mk(0, 0, 0, 1, 1, 8'h90, 1, 0, 0);
`ifdef FETCH_BYPASS_EN
      tbl[25] = mk(0, 0, 0, 1, 1, 8'h94, 1, 1, 8'h90);
      tbl[26] = mk(0, 0, 0, 1, 1, 8'h98, 1, 1, 8'h94);
`else
      tbl[25] = mk(0, 0, 0, 1, 1, 8'h94, 1, 0, 0);
      tbl[26] = mk(0, 0, 0, 1, 1, 8'h98, 1, 1, 8'h90);
`endif
      tbl[27] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[28] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0);
      // backpressure from empty: exactly four requests, then drain in order
      tbl[29] = mk(0, 0, 0, 0, 1, 8'h00, 1, 0, 0);
`ifdef FETCH_BYPASS_EN
      tbl[30] = mk(0, 0, 0, 0, 1, 8'h04, 1, 1, 8'h00);
`else
      tbl[30] = mk(0, 0, 0, 0, 1, 8'h04, 1, 0, 0);
`endif
      tbl[31] = mk(0, 0, 0, 0, 1, 8'h08, 1, 1, 8'h00);
      tbl[32] = mk(0, 0, 0, 0, 1, 8'h0C, 1, 1, 8'h00);
      tbl[33] = mk(0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h00);
      tbl[34] = mk(0, 0, 0, 0, 0, 8'h00, 1, 1, 8'h00);
      tbl[35] = mk(0, 0, 0, 1, 0, 8'h00, 1, 1, 8'h00);
      tbl[36] = mk(0, 0, 0, 1, 1, 8'h10, 1, 1, 8'h04);
      tbl[37] = mk(0, 0, 0, 1, 1, 8'h14, 1, 1, 8'h08);
      tbl[38] = mk(0, 0, 0, 1, 1, 8'h18, 1, 1, 8'h0C);
      tbl[39] = mk(0, 0, 0, 1, 1, 8'h1C, 1, 1, 8'h10);
   endtask

   logic [7:0] wrap_addr [6];

   initial begin
      fill();
      wrap_addr[0] = 8'hF8; wrap_addr[1] = 8'hFC; wrap_addr[2] = 8'h00;
      wrap_addr[3] = 8'h04; wrap_addr[4] = 8'h08; wrap_addr[5] = 8'h0C;
      fw.redirect_en = 1'b0;
      fw.redirect_pc = '0;
      fw.inst_ready  = 1'b1;

      for (int i = 0; i < N; i++) begin
         reset          = tbl[i].rst;
         fi.redirect_en = tbl[i].redir;
         fi.redirect_pc = tbl[i].rpc;
         fi.inst_ready  = tbl[i].rdy;
         @(negedge clk);
         chk("imem_req", i, 32'(fi.imem_req), 32'(tbl[i].ereq));
         if (tbl[i].ereq) chk("imem_addr", i, 32'(fi.imem_addr), 32'(tbl[i].eaddr));
         if (tbl[i].cv) chk("inst_valid", i, 32'(fi.inst_valid), 32'(tbl[i].evld));
         if (tbl[i].cv && tbl[i].evld) begin
            chk("inst_pc", i, 32'(fi.inst_pc), 32'(tbl[i].epc));
            chk("instruction", i, fi.instruction, 32'(tbl[i].epc) + 32'h100);
         end
         if (tbl[i].rst) begin
            chk("rst_inst_pc", i, 32'(fi.inst_pc), 32'h0);
            chk("rst_instruction", i, fi.instruction, 32'h0);
         end
         @(posedge clk);
         #1;
      end

      // PC wrap on the RESET_PC=0xF8 instance
      fi.redirect_en = 1'b0;
      fi.inst_ready  = 1'b1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("wrap_req", c, 32'(fw.imem_req), 32'h1);
         chk("wrap_addr", c, 32'(fw.imem_addr), 32'(wrap_addr[c]));
         chk("wrap_valid", c, 32'(fw.inst_valid), (c >= LAT) ? 32'h1 : 32'h0);
         if (c >= LAT) begin
            chk("wrap_inst_pc", c, 32'(fw.inst_pc), 32'(wrap_addr[c-LAT]));
            chk("wrap_instruction", c, fw.instruction, 32'(wrap_addr[c-LAT]) + 32'h100);
         end
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
